cdb_broadcaster: RTL and testbench



---
 rtl/cdb_broadcaster.sv | 98 +++++++++
 tb/tb_cdb_broadcaster.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/cdb_broadcaster.sv
// Buffers one result per functional unit and broadcasts up to NUM_TAGS per cycle with rotating priority.
// Results reach cdb_* 2 cycles after acceptance; fu_ready is low while a unit's buffer is held ungranted, or on squash/reset.
module cdb_broadcaster #(
    parameter int NUM_FU     = 4,
    parameter int NUM_TAGS   = 3,
    parameter int TAG_SIZE   = 6,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                 clock,
    input  logic                                 reset,
    input  logic                                 squash,
    input  logic [NUM_FU-1:0]                    fu_valid,
    input  logic [NUM_FU-1:0][TAG_SIZE-1:0]      fu_tag,
    input  logic [NUM_FU-1:0][DATA_WIDTH-1:0]    fu_value,
    output logic [NUM_FU-1:0]                    fu_ready,
    output logic [NUM_TAGS-1:0]                  cdb_en,
    output logic [NUM_TAGS-1:0][TAG_SIZE-1:0]    cdb_tag,
    output logic [NUM_TAGS-1:0][DATA_WIDTH-1:0]  cdb_value
);
    localparam int PTR_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
    localparam int CNT_W  = $clog2(NUM_TAGS + 1);
    localparam int LANE_W = (NUM_TAGS > 1) ? $clog2(NUM_TAGS) : 1;

    logic [NUM_FU-1:0]                   buf_valid;
    logic [NUM_FU-1:0][TAG_SIZE-1:0]     buf_tag;
    logic [NUM_FU-1:0][DATA_WIDTH-1:0]   buf_value;
    logic [PTR_W-1:0]                    rr_ptr;

    logic [NUM_FU-1:0]                   grant;
    logic [NUM_FU-1:0]                   accept;
    logic [NUM_TAGS-1:0]                 lane_en;
    logic [NUM_TAGS-1:0][TAG_SIZE-1:0]   lane_tag;
    logic [NUM_TAGS-1:0][DATA_WIDTH-1:0] lane_value;
    logic [PTR_W-1:0]                    next_ptr;
    logic [CNT_W-1:0]                    cnt;
    logic [PTR_W:0]                      scan_sum;
    logic [PTR_W-1:0]                    unit;

    // Walk units in rotated order from rr_ptr; the k-th hit goes to lane k.
    always_comb begin
        grant      = '0;
        lane_en    = '0;
        lane_tag   = '0;
        lane_value = '0;
        next_ptr   = rr_ptr;
        cnt        = '0;
        scan_sum   = '0;
        unit       = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            scan_sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
            if (scan_sum >= (PTR_W+1)'(NUM_FU)) begin
                scan_sum = scan_sum - (PTR_W+1)'(NUM_FU);
            end
            unit = scan_sum[PTR_W-1:0];
            if (buf_valid[unit] && (cnt < CNT_W'(NUM_TAGS))) begin
                grant[unit]                     = 1'b1;
                lane_en[cnt[LANE_W-1:0]]        = 1'b1;
                lane_tag[cnt[LANE_W-1:0]]       = buf_tag[unit];
                lane_value[cnt[LANE_W-1:0]]     = buf_value[unit];
                next_ptr = (unit == PTR_W'(NUM_FU - 1)) ? '0 : unit + PTR_W'(1);
                cnt      = cnt + CNT_W'(1);
            end
        end
    end

    assign fu_ready = {NUM_FU{~reset & ~squash}} & (~buf_valid | grant);
    assign accept   = fu_valid & fu_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_valid <= '0;
            rr_ptr    <= '0;
            cdb_en    <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else if (squash) begin
            buf_valid <= '0;
            cdb_en    <= '0;
            cdb_tag   <= '0;
            cdb_value <= '0;
        end else begin
            // A drained buffer may refill on the same edge, so load wins over clear.
            buf_valid <= (buf_valid & ~grant) | accept;
            for (int i = 0; i < NUM_FU; i++) begin
                if (accept[i]) begin
                    buf_tag[i]   <= fu_tag[i];
                    buf_value[i] <= fu_value[i];
                end
            end
            cdb_en    <= lane_en;
            cdb_tag   <= lane_tag;
            cdb_value <= lane_value;
            if (|grant) begin
                rr_ptr <= next_ptr;
            end
        end
    end
endmodule

// File: tb/tb_cdb_broadcaster.sv
// Directed and random stimulus for cdb_broadcaster against a queue-based reference model.
module tb_cdb_broadcaster;
    localparam int NF = 4;
    localparam int NT = 3;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 squash;
    logic [NF-1:0]        fu_valid;
    logic [NF-1:0][5:0]   fu_tag;
    logic [NF-1:0][63:0]  fu_value;
    logic [NF-1:0]        fu_ready;
    logic [NT-1:0]        cdb_en;
    logic [NT-1:0][5:0]   cdb_tag;
    logic [NT-1:0][63:0]  cdb_value;

    cdb_broadcaster #(.NUM_FU(NF), .NUM_TAGS(NT), .TAG_SIZE(6), .DATA_WIDTH(64)) dut (
        .clock(clock), .reset(reset), .squash(squash),
        .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_value(fu_value), .fu_ready(fu_ready),
        .cdb_en(cdb_en), .cdb_tag(cdb_tag), .cdb_value(cdb_value)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    // Reference model state
    bit  [NF-1:0]        mb_valid;
    logic [NF-1:0][5:0]  mb_tag;
    logic [NF-1:0][63:0] mb_val;
    int                  m_ptr;
    logic [NT-1:0]       e_en;
    logic [NT-1:0][5:0]  e_tag;
    logic [NT-1:0][63:0] e_val;

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
        end
    endtask

    // One clock cycle: check fu_ready, advance the model across the edge, check registered outputs.
    task automatic step();
        int win[$];
        logic [NF-1:0] g, rdy, acc;
        #1;
        win = {};
        for (int k = 0; k < NF; k++) begin
            if (mb_valid[(m_ptr + k) % NF]) win.push_back((m_ptr + k) % NF);
        end
        while (win.size() > NT) void'(win.pop_back());
        g = '0;
        foreach (win[j]) g[win[j]] = 1'b1;
        for (int i = 0; i < NF; i++) rdy[i] = !reset && !squash && (!mb_valid[i] || g[i]);
        check("fu_ready", 64'(fu_ready), 64'(rdy));
        acc = fu_valid & rdy;
        @(posedge clock);
        #1;
        if (reset) begin
            mb_valid = '0; m_ptr = 0; e_en = '0; e_tag = '0; e_val = '0;
        end else if (squash) begin
            mb_valid = '0; e_en = '0; e_tag = '0; e_val = '0;
        end else begin
            e_en = '0; e_tag = '0; e_val = '0;
            foreach (win[j]) begin
                e_en[j]  = 1'b1;
                e_tag[j] = mb_tag[win[j]];
                e_val[j] = mb_val[win[j]];
            end
            for (int i = 0; i < NF; i++) begin
                if (g[i]) mb_valid[i] = 1'b0;
                if (acc[i]) begin
                    mb_valid[i] = 1'b1;
                    mb_tag[i]   = fu_tag[i];
                    mb_val[i]   = fu_value[i];
                end
            end
            if (win.size() > 0) m_ptr = (win[win.size()-1] + 1) % NF;
        end
        check("cdb_en", 64'(cdb_en), 64'(e_en));
        for (int l = 0; l < NT; l++) begin
            check("cdb_tag", 64'(cdb_tag[l]), 64'(e_tag[l]));
            check("cdb_value", cdb_value[l], e_val[l]);
        end
        check("rr_ptr", 64'(dut.rr_ptr), 64'(m_ptr));
    endtask

    task automatic rand_inputs(input logic [NF-1:0] v);
        fu_valid = v;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i]   = 6'($urandom());
            fu_value[i] = {$urandom(), $urandom()};
        end
    endtask

    initial begin
        mb_valid = '0; mb_tag = '0; mb_val = '0; m_ptr = 0;
        e_en = '0; e_tag = '0; e_val = '0;
        reset = 1'b1; squash = 1'b0; fu_valid = '0; fu_tag = '0; fu_value = '0;
        step();
        step();
        check("reset_en", 64'(cdb_en), 64'h0);
        reset = 1'b0;

        // Single result on unit 0
        fu_valid = 4'b0001; fu_tag[0] = 6'd5; fu_value[0] = 64'hA;
        #1;
        check("t1_ready0", 64'(fu_ready[0]), 64'h1);
        step();
        fu_valid = '0;
        step();
        check("t1_en", 64'(cdb_en), 64'h1);
        check("t1_tag", 64'(cdb_tag[0]), 64'd5);
        check("t1_val", cdb_value[0], 64'hA);
        check("t1_ptr", 64'(dut.rr_ptr), 64'd1);
        step();
        check("t1_en_once", 64'(cdb_en), 64'h0);

        // All units once from rr_ptr=0
        reset = 1'b1; step(); reset = 1'b0;
        fu_valid = 4'b1111;
        for (int i = 0; i < NF; i++) begin
            fu_tag[i] = 6'(i + 1); fu_value[i] = 64'(100 + i);
        end
        step();
        fu_valid = '0;
        #1;
        check("t2_ready3", 64'(fu_ready[3]), 64'h0);
        step();
        check("t2_en_a", 64'(cdb_en), 64'h7);
        check("t2_tags_a", 64'(cdb_tag), {46'd0, 6'd3, 6'd2, 6'd1});
        step();
        check("t2_en_b", 64'(cdb_en), 64'h1);
        check("t2_tag_b", 64'(cdb_tag[0]), 64'd4);

        // Saturating load: all units valid for 8 cycles
        reset = 1'b1; step(); reset = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rand_inputs(4'b1111);
            step();
        end
        fu_valid = '0;
        step();
        step();
        step();

        // Squash with three full buffers and two live lanes
        reset = 1'b1; step(); reset = 1'b0;
        rand_inputs(4'b0011); step();
        rand_inputs(4'b0111); step();
        check("sq_bufs", 64'(dut.buf_valid), 64'h7);
        squash = 1'b1; rand_inputs(4'b1111);
        #1;
        check("sq_old_en", 64'(cdb_en), 64'h3);
        check("sq_ready", 64'(fu_ready), 64'h0);
        step();
        squash = 1'b0; fu_valid = '0;
        check("sq_en", 64'(cdb_en), 64'h0);
        check("sq_bufs_empty", 64'(dut.buf_valid), 64'h0);
        check("sq_ptr", 64'(dut.rr_ptr), 64'd2);
        step();

        // Back-to-back results on unit 2
        for (int j = 0; j < 5; j++) begin
            fu_valid = (j < 3) ? 4'b0100 : 4'b0000;
            fu_tag[2] = 6'(7 + j); fu_value[2] = 64'(j);
            step();
            if (j >= 1 && j <= 3) begin
                check("b2b_tag", 64'(cdb_tag[0]), 64'(6 + j));
                check("b2b_en", 64'(cdb_en), 64'h1);
            end
        end

        // Random traffic with occasional squash and reset
        for (int c = 0; c < 300; c++) begin
            rand_inputs(4'($urandom()));
            squash = ($urandom_range(0, 15) == 0);
            reset  = ($urandom_range(0, 63) == 0);
            step();
        end
        squash = 1'b0; reset = 1'b0;

        // Reset overrides squash with full buffers
        rand_inputs(4'b1111); step();
        rand_inputs(4'b1111); step();
        reset = 1'b1; squash = 1'b1;
        step();
        check("rs_en", 64'(cdb_en), 64'h0);
        check("rs_tag", 64'(cdb_tag), 64'h0);
        check("rs_ptr", 64'(dut.rr_ptr), 64'h0);
        check("rs_bufs", 64'(dut.buf_valid), 64'h0);
        reset = 1'b0; squash = 1'b0; fu_valid = '0;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
